// File: rtl/sa_job_sched.sv
// Two-requester arbiter and tile sequencer for the systolic array: grants one
// EKF stage at a time and walks its job tile by tile through compute and writeback.
module sa_job_sched #(
  parameter int RT_W = 4,
  parameter int CT_W = 4
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  input  logic [1:0]      req,
  input  logic [RT_W-1:0] row_tiles0,
  input  logic [CT_W-1:0] col_tiles0,
  input  logic [RT_W-1:0] row_tiles1,
  input  logic [CT_W-1:0] col_tiles1,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic            busy,
  output logic            sa_start,
  input  logic            sa_cal_done,
  output logic [RT_W-1:0] tile_row,
  output logic [CT_W-1:0] tile_col,
  output logic            wb_start,
  input  logic            wb_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, CALC, WB_START, WB_WAIT, NEXT, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [RT_W-1:0] rows;
  logic [CT_W-1:0] cols;
  logic            prio1;
  logic [1:0]      gnt_nxt;
  logic [RT_W-1:0] sel_rows;
  logic [CT_W-1:0] sel_cols;
  logic            last_row, last_col;

  // prio1 is set once requester 0 has been served, so a tie goes to requester 1
  assign gnt_nxt  = (req[1] && (!req[0] || prio1)) ? 2'b10 :
                    (req[0] ? 2'b01 : 2'b00);
  assign sel_rows = gnt[1] ? row_tiles1 : row_tiles0;
  assign sel_cols = gnt[1] ? col_tiles1 : col_tiles0;
  assign last_row = (tile_row == rows - RT_W'(1));
  assign last_col = (tile_col == cols - CT_W'(1));

  assign busy     = (state != IDLE);
  assign sa_start = (state == START);
  assign wb_start = (state == WB_START);
  assign done     = (state == DONE) ? gnt : 2'b00;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req != 2'b00) state_nxt = LOAD;
      LOAD:     state_nxt = (sel_rows == '0 || sel_cols == '0) ? DONE : START;
      START:    state_nxt = CALC;
      CALC:     if (sa_cal_done) state_nxt = WB_START;
      WB_START: state_nxt = WB_WAIT;
      WB_WAIT:  if (wb_done) state_nxt = NEXT;
      NEXT:     state_nxt = (last_row && last_col) ? DONE : START;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt      <= 2'b00;
      rows     <= '0;
      cols     <= '0;
      tile_row <= '0;
      tile_col <= '0;
      prio1    <= 1'b0;
    end else begin
      case (state)
        IDLE: gnt <= gnt_nxt;
        LOAD: begin
          rows     <= sel_rows;
          cols     <= sel_cols;
          tile_row <= '0;
          tile_col <= '0;
        end
        NEXT: begin
          if (last_col) begin
            tile_col <= '0;
            tile_row <= tile_row + RT_W'(1);
          end else begin
            tile_col <= tile_col + CT_W'(1);
          end
        end
        DONE: begin
          gnt   <= 2'b00;
          prio1 <= gnt[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_job_sched.sv
// Directed bench for sa_job_sched: emulates the array and writeback handshakes
// and checks tile order, grants, done pulses and job timing.
module tb_sa_job_sched;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic [1:0] req;
  logic [3:0] row_tiles0, col_tiles0, row_tiles1, col_tiles1;
  logic [1:0] gnt, done;
  logic       busy, sa_start, sa_cal_done, wb_start, wb_done;
  logic [3:0] tile_row, tile_col;

  int checks = 0;
  int errors = 0;

  sa_job_sched #(.RT_W(4), .CT_W(4)) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .req         (req),
    .row_tiles0  (row_tiles0),
    .col_tiles0  (col_tiles0),
    .row_tiles1  (row_tiles1),
    .col_tiles1  (col_tiles1),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .sa_start    (sa_start),
    .sa_cal_done (sa_cal_done),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .wb_start    (wb_start),
    .wb_done     (wb_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input int r0, input int c0,
                               input int r1, input int c1);
    req        = r;
    row_tiles0 = 4'(r0);
    col_tiles0 = 4'(c0);
    row_tiles1 = 4'(r1);
    col_tiles1 = 4'(c1);
  endtask

  // Plays the array and writeback units for one job; lat extra cycles per
  // handshake, and with stale set the wrong-phase done pulses are injected.
  task automatic runJob(input string tag, input logic [1:0] exp_gnt, input int rows,
                        input int cols, input int lat, input bit stale,
                        input logic [1:0] req_after);
    int  cyc = 0, gnt_cyc = 0, done_cyc = 0, starts = 0, wbs = 0;
    int  er = 0, ec = 0, last_r = -1, last_c = -1, cal_cnt = 0, wb_cnt = 0;
    int  tiles = rows * cols;
    int  exp_len;
    bit  gnt_seen = 0, finished = 0, gnt_bad = 0, tile_bad = 0;
    exp_len = (tiles == 0) ? 1 : 6 + 5 * (tiles - 1) + 2 * lat * tiles;
    while (!finished && cyc < 5000) begin
      sa_cal_done = (cal_cnt == 1) || (stale && wb_cnt > 1);
      wb_done     = (wb_cnt == 1) || (stale && cal_cnt > 1);
      if (cal_cnt > 0) cal_cnt--;
      if (wb_cnt > 0) wb_cnt--;
      if (!gnt_seen && gnt != 2'b00) begin
        gnt_seen = 1;
        gnt_cyc  = cyc;
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
      end else if (gnt_seen && gnt != exp_gnt) begin
        gnt_bad = 1;
      end
      if (sa_start) begin
        checkOutput({tag, ".tile"}, 32'({tile_row, tile_col}), 32'(er * 16 + ec));
        last_r  = int'(tile_row);
        last_c  = int'(tile_col);
        starts++;
        cal_cnt = 1 + lat;
        ec++;
        if (ec == cols) begin
          ec = 0;
          er++;
        end
      end
      if (wb_start) begin
        wbs++;
        wb_cnt = 1 + lat;
        if (int'(tile_row) != last_r || int'(tile_col) != last_c) tile_bad = 1;
      end
      if (done != 2'b00) begin
        finished = 1;
        done_cyc = cyc;
        checkOutput({tag, ".done"}, 32'(done), 32'(exp_gnt));
        req = req_after;
      end
      tick();
      cyc++;
    end
    sa_cal_done = 1'b0;
    wb_done     = 1'b0;
    checkOutput({tag, ".finished"}, 32'(finished), 32'd1);
    checkOutput({tag, ".starts"}, 32'(starts), 32'(tiles));
    checkOutput({tag, ".wbs"}, 32'(wbs), 32'(tiles));
    checkOutput({tag, ".gnt_held"}, 32'(gnt_bad), 32'd0);
    checkOutput({tag, ".tile_stable"}, 32'(tile_bad), 32'd0);
    checkOutput({tag, ".length"}, 32'(done_cyc - gnt_cyc), 32'(exp_len));
    if (tiles > 0)
      checkOutput({tag, ".last_tile"}, 32'(last_r * 16 + last_c),
                  32'((rows - 1) * 16 + (cols - 1)));
    // one cycle after DONE the block is back in IDLE with the grant released
    checkOutput({tag, ".after"}, 32'({busy, gnt, done}), 32'd0);
  endtask

  task automatic resetDut();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset.outputs",
                32'({gnt, done, busy, sa_start, wb_start, tile_row, tile_col}), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    sa_cal_done = 1'b0;
    wb_done     = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0);
    resetDut();

    // 2x3 raster for requester 0
    applyStimulus(2'b01, 2, 3, 0, 0);
    runJob("raster", 2'b01, 2, 3, 0, 0, 2'b00);

    // round-robin: ties alternate, starting with requester 0 after reset
    resetDut();
    applyStimulus(2'b11, 1, 1, 1, 1);
    runJob("rr_a", 2'b01, 1, 1, 0, 0, 2'b11);
    runJob("rr_b", 2'b10, 1, 1, 0, 0, 2'b11);
    runJob("rr_c", 2'b01, 1, 1, 0, 0, 2'b10);
    runJob("rr_d", 2'b10, 1, 1, 0, 0, 2'b00);

    // zero counts: no array activity, done one cycle after the grant appears
    applyStimulus(2'b10, 0, 0, 0, 5);
    runJob("zero_rows", 2'b10, 0, 5, 0, 0, 2'b00);
    applyStimulus(2'b01, 3, 0, 0, 0);
    runJob("zero_cols", 2'b01, 3, 0, 0, 0, 2'b00);

    // wrong-phase handshake pulses must not move the sequencer
    applyStimulus(2'b01, 1, 2, 0, 0);
    runJob("stale", 2'b01, 1, 2, 2, 1, 2'b00);

    // asynchronous reset during CALC of a 4x4 job
    applyStimulus(2'b01, 4, 4, 0, 0);
    for (int i = 0; i < 50 && !sa_start; i++) tick();
    checkOutput("abort.start_seen", 32'(sa_start), 32'd1);
    tick();
    checkOutput("abort.busy_before", 32'({busy, gnt}), 32'b101);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("abort.async_clear",
                32'({gnt, done, busy, sa_start, wb_start, tile_row, tile_col}), 32'd0);
    tick();
    tick();
    checkOutput("abort.no_done", 32'({done, busy}), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    tick();
    runJob("restart", 2'b01, 4, 4, 0, 0, 2'b00);

    // maximum counts
    applyStimulus(2'b01, 15, 15, 0, 0);
    runJob("max", 2'b01, 15, 15, 0, 0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
